// File: rtl/mem_cmd_ctrl.sv
// Command front-end for a 32 x 8 synchronous memory: buffers read/write commands in an
// in-order FIFO and sequences them onto the memory pins. Optional macro: MEM_CMD_STATS_EN.
module mem_cmd_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
`ifdef MEM_CMD_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StExec, StRdWait} state_e;

    state_e            state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    logic              fifo_write [DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_data  [DEPTH];

    logic push;
    logic pop;

    // Ready comes from the registered count only: a full FIFO refuses even while popping.
    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid && cmd_ready && !rst;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign busy      = (count_q != '0) || (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr_q] <= cmd_write;
            fifo_addr[wr_ptr_q]  <= cmd_addr;
            fifo_data[wr_ptr_q]  <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        mem_addr    <= fifo_addr[rd_ptr_q];
                        mem_data_in <= fifo_data[rd_ptr_q];
                        mem_write   <= fifo_write[rd_ptr_q];
                        mem_read    <= !fifo_write[rd_ptr_q];
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state_q   <= mem_write ? StIdle : StRdWait;
                end
                StRdWait: begin
                    // Memory data is valid now, one cycle after it sampled mem_read.
                    rsp_valid <= 1'b1;
                    rsp_addr  <= mem_addr;
                    rsp_data  <= mem_data_out;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef MEM_CMD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (mem_write && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rsp_valid && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Scoreboard bench for mem_cmd_ctrl with a behavioural 32 x 8 synchronous memory.
// Build with MEM_CMD_STATS_EN defined to also exercise the statistics counters.
module tb_mem_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_data_out;
    logic       rsp_valid;
    logic [4:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef MEM_CMD_STATS_EN
    logic [15:0] wr_count;
    logic [15:0] rd_count;
`endif

    always #5 clk = ~clk;

    mem_cmd_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .busy         (busy)
`ifdef MEM_CMD_STATS_EN
        ,
        .wr_count     (wr_count),
        .rd_count     (rd_count)
`endif
    );

    // Behavioural memory: read data appears the cycle after mem_read is sampled.
    logic [7:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem_data_out = 8'h00;
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read) mem_data_out <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         c;  // expected cycle, -1 when latency is not checked
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write strobe or response.
    exp_t we;
    exp_t re;
    always @(negedge clk) begin
        if (mem_read && mem_write) flag("strobes_both_high");
        if (mem_write) begin
            if (wq.size() == 0) begin
                flag("unexpected_mem_write");
            end else begin
                we = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(we.a));
                chk("wr_data", 32'(mem_data_in), 32'(we.d));
                if (we.c >= 0) chk("wr_cycle", 32'(cyc), 32'(we.c));
            end
        end
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                flag("unexpected_rsp_valid");
            end else begin
                re = rq.pop_front();
                chk("rsp_addr", 32'(rsp_addr), 32'(re.a));
                chk("rsp_data", 32'(rsp_data), 32'(re.d));
                if (re.c >= 0) chk("rsp_cycle", 32'(cyc), 32'(re.c));
            end
        end
    end

    // Called at a negedge; holds cmd_valid and returns the cycle in which it was accepted.
    task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d,
                        output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        for (int t = 0; t < 50; t++) begin
            int   c;
            logic r;
            c = cyc;
            r = cmd_ready;
            @(negedge clk);
            if (r) begin
                acc = c;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) flag("send_timeout");
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy && wq.size() == 0 && rq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) flag("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);

        // Single write then read, with exact latency
        send(1'b1, 5'h0A, 8'h5C, acc);
        wq.push_back('{5'h0A, 8'h5C, acc + 2});
        idle();
        drain();
        send(1'b0, 5'h0A, 8'h00, acc);
        rq.push_back('{5'h0A, 8'h5C, acc + 4});
        idle();
        drain();
        chk("rsp_hold_addr", 32'(rsp_addr), 32'h0A);
        chk("rsp_hold_data", 32'(rsp_data), 32'h5C);
        chk("mem_addr_hold", 32'(mem_addr), 32'h0A);

        // Back-to-back writes: FIFO fills, one refused cycle, strobes every 2 cycles
        base = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 5'(i), 8'(i), acc);
            if (i == 0) base = acc;
            wq.push_back('{5'(i), 8'(i), base + 2 + 2 * i});
            if (i == 6) chk("accept_cycle_6", 32'(acc), 32'(base + 6));
            if (i == 7) chk("accept_cycle_7_after_full", 32'(acc), 32'(base + 8));
        end
        idle();
        drain();

        // Address extremes, responses in order
        send(1'b1, 5'h1F, 8'hFF, acc);
        wq.push_back('{5'h1F, 8'hFF, -1});
        send(1'b1, 5'h00, 8'h01, acc);
        wq.push_back('{5'h00, 8'h01, -1});
        send(1'b0, 5'h1F, 8'h00, acc);
        rq.push_back('{5'h1F, 8'hFF, -1});
        send(1'b0, 5'h00, 8'h00, acc);
        rq.push_back('{5'h00, 8'h01, -1});
        idle();
        drain();

        // Reset during RD_WAIT kills the response; command held during reset is dropped
        send(1'b0, 5'h0A, 8'h00, acc);
        idle();
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'h0A;
        cmd_data  = 8'hEE;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mem_read", 32'(mem_read), 32'd0);
        chk("midrst_mem_write", 32'(mem_write), 32'd0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_cmd_not_accepted", 32'(busy), 32'd0);
        send(1'b0, 5'h0A, 8'h00, acc);
        rq.push_back('{5'h0A, 8'h5C, acc + 4});
        idle();
        drain();

`ifdef MEM_CMD_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("stats_wr_after_rst", 32'(wr_count), 32'd0);
        chk("stats_rd_after_rst", 32'(rd_count), 32'd0);
        for (int i = 0; i < 32; i++) begin
            send(1'b1, 5'(i), 8'(i * 7 + 3), acc);
            wq.push_back('{5'(i), 8'(i * 7 + 3), -1});
        end
        for (int i = 0; i < 32; i++) begin
            send(1'b0, 5'(i), 8'h00, acc);
            rq.push_back('{5'(i), 8'(i * 7 + 3), -1});
        end
        idle();
        drain();
        chk("stats_wr_count", 32'(wr_count), 32'd32);
        chk("stats_rd_count", 32'(rd_count), 32'd32);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("stats_wr_cleared", 32'(wr_count), 32'd0);
        chk("stats_rd_cleared", 32'(rd_count), 32'd0);
`endif

        if (wq.size() != 0 || rq.size() != 0) flag("scoreboard_not_empty");
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
